base64_pixel_writer: RTL
========================

# base64_pixel_writer

Parametrised successor to the first-generation image store path. Accepts a base64 character stream from the UART receive module and decodes it with correct `=` padding handling and whitespace skipping. It unpacks the decoded bytes into BPP-bit pixels, MSB first, and drives a simple synchronous write port into the frame-buffer RAM. It also reports frame status and sticky error flags to the display controller.

## Interface
Parameters:
- BPP, 2, bits per pixel; legal values 1, 2, 4, 8.
- ADDR_W, 16, width of the pixel write address.
- MAX_PIXELS, 32768, frame-buffer capacity in pixels; must be ≤ 2^ADDR_W.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock (27 MHz); all state on posedge clk.
- reset_n  in  1  asynchronous active-low reset.
- data_in  in  8  ASCII character from the receive module.
- data_valid  in  1  data_in valid; a character is accepted when data_valid && data_ready.
- data_ready  out  1  block can accept a character.
- image_start  in  1  one-cycle pulse: begin a new frame (aborts any frame in progress).
- image_end  in  1  one-cycle pulse: frame stream finished.
- chunk_complete  in  1  one-cycle pulse: transport chunk boundary; counted only.
- wr_en  out  1  pixel write strobe.
- wr_addr  out  ADDR_W  pixel address.
- wr_data  out  BPP  pixel value.
- writing_active  out  1  frame in progress.
- frame_valid  out  1  a complete frame is in RAM; level output.
- image_done  out  1  one-cycle pulse at frame completion.
- pixel_count  out  ADDR_W+1  pixels written in the current or last frame.
- chunk_count  out  16  chunk_complete pulses seen in the current frame; wraps.
- err_char  out  1  sticky: illegal character or misplaced `=`.
- err_overflow  out  1  sticky: pixel beyond MAX_PIXELS dropped.
- err_trunc  out  1  sticky: image_end with a partial 4-char group.

## Operation
- Reset values: all outputs 0, data_ready 0, state IDLE.
- Character classes:
  - A–Z → 0–25; a–z → 26–51; 0–9 → 52–61; `+` → 62; `/` → 63.
  - `=` is padding.
  - 0x20, 0x09, 0x0D, 0x0A are whitespace: accepted and ignored.
  - Anything else: accepted, ignored, err_char set.
- Group counter grp (0..3) and pad count:
  - `=` is legal only at grp 2 or grp 3.
  - `=` at grp 2 requires the next non-whitespace character to be `=`. If it is not, set err_char, discard the character and treat the group as `==`.
  - `=` at grp 0 or grp 1: err_char set, character ignored.
- Group completion: the 4th symbol forms 24 bits, big-endian. Valid bytes = 3 − pad. Pixels per group P = bytes·8/BPP, emitted MSB first within each byte.
- States:
  - IDLE: data_ready 0.
    - image_start → COLLECT. Clears pixel_count, chunk_count, grp, all err flags, frame_valid. Sets writing_active.
  - COLLECT: data_ready 1; accepts characters.
    - Group complete → EMIT.
    - image_end → DONE. If grp≠0 (partial group discarded), also set err_trunc.
  - EMIT: data_ready 0. One pixel per cycle for P cycles, then back to COLLECT.
    - An image_end arriving during EMIT is latched as pending. It is acted on, with the same DONE rules, after the last pixel.
  - DONE, one cycle: image_done = 1, frame_valid = 1, writing_active = 0 → IDLE.
- Address handling:
  - wr_addr = pixel_count at the time of each write.
  - If pixel_count == MAX_PIXELS, the write is suppressed (wr_en 0, count holds), err_overflow is set, and emission still runs its P cycles.
- Any state: image_start → COLLECT with the clears above. Any in-flight EMIT is abandoned.
- chunk_complete increments chunk_count in COLLECT/EMIT. It never alters grp.
- Simultaneous inputs in COLLECT:
  - image_start beats image_end.
  - An accepted character on the same cycle as image_end is processed first; the group check uses the updated grp.

## Timing
- If the 4th group symbol is accepted on edge N:
  - first wr_en is high in cycle N+1;
  - writes occupy cycles N+1..N+P;
  - data_ready is high again in cycle N+P+1.
- wr_en, wr_addr, wr_data are registered and change only on clk.
- Throughput at BPP=2 is 16 cycles per full group (4 accept + 12 write).
- image_done is asserted the cycle after the final write, or after the image_end edge when no emission is pending.
- Reset assertion takes effect immediately and asynchronously on all outputs; release is synchronous to clk.

## Test plan
- BPP=2, "TWFu" then image_end → wr_en for 12 consecutive cycles, addr 0..11, data 1,0,3,1,1,2,0,1,1,2,3,2; image_done pulse; pixel_count=12; no errors.
- BPP=2, "TQ==" → 4 writes: data 1,0,3,1. BPP=8, "TWFu" → 3 writes: 0x4D, 0x61, 0x6E.
- BPP=2, "TW\r\nFu" → same output as scenario 1, err_char 0. "TW*Fu" → same output, err_char 1.
- BPP=2, MAX_PIXELS=8, "TWFu" → writes at addr 0..7 only, err_overflow 1, pixel_count=8, data_ready is low for 12 cycles.
- "TWF" then image_end → no writes, err_trunc 1, frame_valid 1. chunk_complete pulsed between "TW" and "Fu" → normal 12 writes, chunk_count 1.
- reset_n low in EMIT mid-group → outputs 0 immediately. After release, image_start plus "TWFu" writes from addr 0 again.

Source files
------------

// File: rtl/base64_pixel_writer.sv
// base64_pixel_writer
//   Decodes a base64 character stream into bytes. Handles '=' padding and
//   skips whitespace. Each decoded byte is unpacked into BPP-bit pixels,
//   MSB first, and every pixel is written through a registered port into
//   the frame-buffer RAM.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   data_in/data_valid/data_ready  character stream handshake
//   image_start/image_end        frame delimiters (one-cycle pulses)
//   chunk_complete               transport chunk pulse (counted only)
//   wr_en/wr_addr/wr_data        pixel write port (registered)
//   writing_active, frame_valid, image_done, pixel_count, chunk_count
//   err_char, err_overflow, err_trunc   sticky error flags, cleared by image_start
module base64_pixel_writer #(
  parameter int BPP        = 2,
  parameter int ADDR_W     = 16,
  parameter int MAX_PIXELS = 32768
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        data_in,
  input  logic              data_valid,
  output logic              data_ready,
  input  logic              image_start,
  input  logic              image_end,
  input  logic              chunk_complete,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [BPP-1:0]    wr_data,
  output logic              writing_active,
  output logic              frame_valid,
  output logic              image_done,
  output logic [ADDR_W:0]   pixel_count,
  output logic [15:0]       chunk_count,
  output logic              err_char,
  output logic              err_overflow,
  output logic              err_trunc
);

  localparam int              PIX_PER_BYTE = 8 / BPP;
  localparam logic [ADDR_W:0] MAX_CNT      = (ADDR_W + 1)'(MAX_PIXELS);
  localparam logic [ADDR_W:0] CNT_ONE      = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_EMIT, S_DONE} state_t;
  typedef enum logic [1:0] {C_SYM, C_PAD, C_WS, C_BAD} cls_t;

  state_t              state_q, state_d;
  logic [1:0]          grp_q, grp_d;
  logic                pad_exp_q, pad_exp_d;   // '=' seen at grp 2, a second '=' must follow
  logic [17:0]         acc_q, acc_d;           // first three sextets of the group
  logic [23:0]         shreg_q, shreg_d;       // decoded group, shifted out MSB first
  logic [4:0]          pix_left_q, pix_left_d; // pixels still to issue after the current one
  logic                end_pend_q, end_pend_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [BPP-1:0]      wr_data_q, wr_data_d;
  logic [ADDR_W:0]     pixel_count_q, pixel_count_d;
  logic [15:0]         chunk_count_q, chunk_count_d;
  logic                err_char_q, err_char_d;
  logic                err_ovf_q, err_ovf_d;
  logic                err_trunc_q, err_trunc_d;
  logic                frame_valid_q, frame_valid_d;
  logic                active_q, active_d;

  cls_t                cls;
  logic [5:0]          sym_val;
  logic                grp_done;
  logic [5:0]          fin_sext;
  logic [1:0]          fin_pad;
  logic [23:0]         word;
  logic                issue;
  logic [BPP-1:0]      issue_pix;

  // Character classification.
  always_comb begin
    cls     = C_BAD;
    sym_val = 6'd0;
    if (data_in >= 8'h41 && data_in <= 8'h5A) begin
      cls     = C_SYM;
      sym_val = 6'(data_in - 8'h41);
    end else if (data_in >= 8'h61 && data_in <= 8'h7A) begin
      cls     = C_SYM;
      sym_val = 6'(data_in - 8'h47);
    end else if (data_in >= 8'h30 && data_in <= 8'h39) begin
      cls     = C_SYM;
      sym_val = 6'(data_in + 8'h04);
    end else if (data_in == 8'h2B) begin
      cls     = C_SYM;
      sym_val = 6'd62;
    end else if (data_in == 8'h2F) begin
      cls     = C_SYM;
      sym_val = 6'd63;
    end else if (data_in == 8'h3D) begin
      cls = C_PAD;
    end else if (data_in inside {8'h20, 8'h09, 8'h0D, 8'h0A}) begin
      cls = C_WS;
    end
  end

  always_comb begin
    // NOTE: every *_d and temporary takes a hold/default value first, so no
    // path through the case statements can leave one unassigned (no latches).
    state_d       = state_q;
    grp_d         = grp_q;
    pad_exp_d     = pad_exp_q;
    acc_d         = acc_q;
    shreg_d       = shreg_q;
    pix_left_d    = pix_left_q;
    end_pend_d    = end_pend_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    pixel_count_d = pixel_count_q;
    chunk_count_d = chunk_count_q;
    err_char_d    = err_char_q;
    err_ovf_d     = err_ovf_q;
    err_trunc_d   = err_trunc_q;
    frame_valid_d = frame_valid_q;
    active_d      = active_q;
    grp_done      = 1'b0;
    fin_sext      = 6'd0;
    fin_pad       = 2'd0;
    word          = 24'd0;
    issue         = 1'b0;
    issue_pix     = '0;

    if (image_start) begin
      // A new frame wins over everything else, including an in-flight EMIT.
      state_d       = S_COLLECT;
      grp_d         = 2'd0;
      pad_exp_d     = 1'b0;
      acc_d         = '0;
      pix_left_d    = '0;
      end_pend_d    = 1'b0;
      pixel_count_d = '0;
      chunk_count_d = '0;
      err_char_d    = 1'b0;
      err_ovf_d     = 1'b0;
      err_trunc_d   = 1'b0;
      frame_valid_d = 1'b0;
      active_d      = 1'b1;
    end else begin
      if (chunk_complete && (state_q == S_COLLECT || state_q == S_EMIT))
        chunk_count_d = chunk_count_q + 16'd1;

      unique case (state_q)
        S_IDLE: ;
        S_COLLECT: begin
          if (data_valid) begin
            unique case (cls)
              C_WS: ;
              C_SYM, C_BAD: begin
                if (cls == C_BAD) err_char_d = 1'b1;
                if (pad_exp_q) begin
                  // Lone '=' at grp 2: drop this character, close the group as '=='.
                  err_char_d = 1'b1;
                  grp_done   = 1'b1;
                  fin_pad    = 2'd2;
                end else if (cls == C_SYM) begin
                  if (grp_q == 2'd3) begin
                    grp_done = 1'b1;
                    fin_sext = sym_val;
                  end else begin
                    acc_d = {acc_q[11:0], sym_val};
                    grp_d = grp_q + 2'd1;
                  end
                end
              end
              C_PAD: begin
                if (pad_exp_q) begin
                  grp_done = 1'b1;
                  fin_pad  = 2'd2;
                end else if (grp_q == 2'd3) begin
                  grp_done = 1'b1;
                  fin_pad  = 2'd1;
                end else if (grp_q == 2'd2) begin
                  acc_d     = {acc_q[11:0], 6'd0};
                  grp_d     = 2'd3;
                  pad_exp_d = 1'b1;
                end else begin
                  err_char_d = 1'b1;
                end
              end
              default: ;
            endcase
          end

          if (grp_done) begin
            // The first pixel goes out on the same edge that completes the group.
            word       = {acc_q, fin_sext};
            grp_d      = 2'd0;
            pad_exp_d  = 1'b0;
            acc_d      = '0;
            issue      = 1'b1;
            issue_pix  = word[23 -: BPP];
            shreg_d    = word << BPP;
            pix_left_d = 5'(((3 - int'(fin_pad)) * PIX_PER_BYTE) - 1);
            end_pend_d = image_end;
            state_d    = S_EMIT;
          end else if (image_end) begin
            if (grp_d != 2'd0) err_trunc_d = 1'b1;
            state_d       = S_DONE;
            frame_valid_d = 1'b1;
            active_d      = 1'b0;
          end
        end
        S_EMIT: begin
          if (image_end) end_pend_d = 1'b1;
          if (pix_left_q != 5'd0) begin
            issue      = 1'b1;
            issue_pix  = shreg_q[23 -: BPP];
            shreg_d    = shreg_q << BPP;
            pix_left_d = pix_left_q - 5'd1;
          end else if (end_pend_q || image_end) begin
            end_pend_d    = 1'b0;
            state_d       = S_DONE;
            frame_valid_d = 1'b1;
            active_d      = 1'b0;
          end else begin
            state_d = S_COLLECT;
          end
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    // A full frame buffer still consumes the emission slot, but drops the write.
    if (issue) begin
      if (pixel_count_q == MAX_CNT) begin
        err_ovf_d = 1'b1;
      end else begin
        wr_en_d       = 1'b1;
        wr_addr_d     = pixel_count_q[ADDR_W-1:0];
        wr_data_d     = issue_pix;
        pixel_count_d = pixel_count_q + CNT_ONE;
      end
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      grp_q         <= 2'd0;
      pad_exp_q     <= 1'b0;
      acc_q         <= '0;
      shreg_q       <= '0;
      pix_left_q    <= '0;
      end_pend_q    <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      pixel_count_q <= '0;
      chunk_count_q <= '0;
      err_char_q    <= 1'b0;
      err_ovf_q     <= 1'b0;
      err_trunc_q   <= 1'b0;
      frame_valid_q <= 1'b0;
      active_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      grp_q         <= grp_d;
      pad_exp_q     <= pad_exp_d;
      acc_q         <= acc_d;
      shreg_q       <= shreg_d;
      pix_left_q    <= pix_left_d;
      end_pend_q    <= end_pend_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      pixel_count_q <= pixel_count_d;
      chunk_count_q <= chunk_count_d;
      err_char_q    <= err_char_d;
      err_ovf_q     <= err_ovf_d;
      err_trunc_q   <= err_trunc_d;
      frame_valid_q <= frame_valid_d;
      active_q      <= active_d;
    end
  end

  assign data_ready     = (state_q == S_COLLECT);
  assign image_done     = (state_q == S_DONE);
  assign wr_en          = wr_en_q;
  assign wr_addr        = wr_addr_q;
  assign wr_data        = wr_data_q;
  assign writing_active = active_q;
  assign frame_valid    = frame_valid_q;
  assign pixel_count    = pixel_count_q;
  assign chunk_count    = chunk_count_q;
  assign err_char       = err_char_q;
  assign err_overflow   = err_ovf_q;
  assign err_trunc      = err_trunc_q;

endmodule
